// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: PDM microphone record-path front end.
// Latency: each word is presented on o_fifo_wr/o_fifo_din the cycle after the edge that captures its last bit.
// Backpressure: never stalls; a word completing against a full FIFO is dropped and counted (saturating at 255).
//
// Ports:
//   mclk, reset          mic bit clock (rising edge); synchronous active-high reset
//   i_start, i_abort     level-sampled record request / cancel (abort wins)
//   i_rec_len            number of words to record, latched on an accepted start
//   i_mic_data           1-bit PDM stream, packed MSB-first
//   i_fifo_full          audio FIFO full flag, sampled on word-complete edges
//   o_mic_en, o_busy     high during SETTLE and RECORD
//   o_fifo_wr/o_fifo_din one-cycle write strobe and packed word (word holds between writes)
//   o_done               one-cycle pulse at normal completion
//   o_overrun(_count)    sticky drop flag and saturating drop counter for this recording
module pdm_mic_capture #(
    parameter int WORD_W     = 8,
    parameter int LEN_W      = 20,
    parameter int SETTLE_CYC = 1024
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [LEN_W-1:0]  i_rec_len,
    input  logic              i_mic_data,
    input  logic              i_fifo_full,
    output logic              o_mic_en,
    output logic              o_fifo_wr,
    output logic [WORD_W-1:0] o_fifo_din,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic [7:0]        o_overrun_count
);

    localparam int BCW = $clog2(WORD_W);
    localparam int SCW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RECORD = 2'd2
    } state_t;

    state_t            r_state;
    logic [SCW-1:0]    r_settle_cnt;
    logic [BCW-1:0]    r_bit_cnt;
    logic [LEN_W-1:0]  r_word_cnt;
    logic [LEN_W-1:0]  r_len;
    // Holds the first WORD_W-1 bits of the word in flight; the last bit
    // comes straight from the pin so the word is complete on its final edge.
    logic [WORD_W-2:0] r_shift;

    logic [WORD_W-1:0] w_word;
    logic              w_last_bit;
    logic [LEN_W-1:0]  w_word_cnt_nxt;
    logic              w_final;

    assign w_word         = {r_shift, i_mic_data};
    assign w_last_bit     = (r_bit_cnt == BCW'(WORD_W - 1));
    assign w_word_cnt_nxt = r_word_cnt + 1'b1;
    assign w_final        = (w_word_cnt_nxt == r_len);

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_settle_cnt    <= '0;
            r_bit_cnt       <= '0;
            r_word_cnt      <= '0;
            r_len           <= '0;
            r_shift         <= '0;
            o_mic_en        <= 1'b0;
            o_fifo_wr       <= 1'b0;
            o_fifo_din      <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_overrun       <= 1'b0;
            o_overrun_count <= '0;
        end else begin
            o_fifo_wr <= 1'b0;
            o_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        r_len           <= i_rec_len;
                        o_overrun       <= 1'b0;
                        o_overrun_count <= '0;
                        r_bit_cnt       <= '0;
                        r_word_cnt      <= '0;
                        r_settle_cnt    <= '0;
                        if (i_rec_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            r_state  <= SETTLE;
                            o_busy   <= 1'b1;
                            o_mic_en <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        o_busy   <= 1'b0;
                        o_mic_en <= 1'b0;
                    end else if (r_settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                        r_state <= RECORD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                RECORD: begin
                    if (i_abort) begin
                        // Partial word is simply abandoned; drop stats stay visible.
                        r_state  <= IDLE;
                        o_busy   <= 1'b0;
                        o_mic_en <= 1'b0;
                    end else begin
                        r_shift <= w_word[WORD_W-2:0];
                        if (w_last_bit) begin
                            r_bit_cnt  <= '0;
                            r_word_cnt <= w_word_cnt_nxt;
                            if (!i_fifo_full) begin
                                o_fifo_wr  <= 1'b1;
                                o_fifo_din <= w_word;
                            end else begin
                                o_overrun <= 1'b1;
                                if (o_overrun_count != 8'hFF) begin
                                    o_overrun_count <= o_overrun_count + 1'b1;
                                end
                            end
                            // Length counts words captured, not words written.
                            if (w_final) begin
                                r_state  <= IDLE;
                                o_done   <= 1'b1;
                                o_busy   <= 1'b0;
                                o_mic_en <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    o_busy   <= 1'b0;
                    o_mic_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb_pdm_mic_capture: randomized scenarios checked against a timing model of the recorder.
// Latency: model expects word n at the cycle after edge SETTLE+(n+1)*WORD_W relative to the start edge.
// Backpressure: fifo_full patterns are generated per edge and dropped words are predicted from them.
module tb_pdm_mic_capture;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int LW = 20;
    localparam int NONE = 1 << 30;

    logic          mclk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_abort;
    logic [LW-1:0] i_rec_len;
    logic          i_mic_data;
    logic          i_fifo_full;
    logic          o_mic_en;
    logic          o_fifo_wr;
    logic [W-1:0]  o_fifo_din;
    logic          o_busy;
    logic          o_done;
    logic          o_overrun;
    logic [7:0]    o_overrun_count;

    int checks = 0;
    int errors = 0;

    bit           mic_arr  [0:2999];
    bit           full_arr [0:2999];
    logic [W-1:0] exp_din;

    pdm_mic_capture #(.WORD_W(W), .LEN_W(LW), .SETTLE_CYC(S)) dut (
        .mclk            (mclk),
        .reset           (reset),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_rec_len       (i_rec_len),
        .i_mic_data      (i_mic_data),
        .i_fifo_full     (i_fifo_full),
        .o_mic_en        (o_mic_en),
        .o_fifo_wr       (o_fifo_wr),
        .o_fifo_din      (o_fifo_din),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_overrun       (o_overrun),
        .o_overrun_count (o_overrun_count)
    );

    always #5 mclk = ~mclk;

    // Idle gap: nothing may start, write or finish while start is low.
    task automatic idle_gap(input int n);
        i_start = 1'b0;
        i_abort = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_mic_data  = 1'($urandom);
            i_fifo_full = 1'($urandom);
            @(posedge mclk);
            #1;
            checks++;
            if ({o_busy, o_fifo_wr, o_done} !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet: busy/wr/done=%b required 000", {o_busy, o_fifo_wr, o_done});
            end
        end
    endtask

    // One recording, driven edge by edge from E0. full_mode: 0 never full,
    // 1 full only at full_edge, 2 always full, 3 random. Edges are numbered
    // relative to the start edge E0; abort_at/reset_at use the same numbering.
    task automatic run_rec(input string name, input int len, input bit rnd_mic,
                           input int full_mode, input int full_edge, input int abort_at,
                           input bit hold_start, input int reset_at);
        int t, a, r, last, drops, nwr, exp_total, e_cnt, e;
        bit word_edge, e_busy, e_wr, e_done;
        logic [W-1:0] pat, w;
        pat = 8'hB2;
        t = (len == 0) ? 0 : S + len * W;
        a = (abort_at < 0) ? NONE : abort_at;
        r = (reset_at < 0) ? NONE : reset_at;
        last = t;
        if (a < last) last = a;
        if (r < last) last = r;
        last = last + 3;
        for (int k = 0; k <= last; k++) begin
            mic_arr[k] = rnd_mic ? 1'($urandom) : pat[7 - ((k + 64 - S - 1) % 8)];
            case (full_mode)
                0:       full_arr[k] = 1'b0;
                1:       full_arr[k] = (k == full_edge);
                2:       full_arr[k] = 1'b1;
                default: full_arr[k] = ($urandom_range(3) == 0);
            endcase
        end
        exp_total = 0;
        for (int n = 0; n < len; n++) begin
            e = S + (n + 1) * W;
            if (e < a && e < r && !full_arr[e]) exp_total++;
        end
        drops = 0;
        nwr = 0;
        for (int k = 0; k <= last; k++) begin
            i_mic_data  = mic_arr[k];
            i_fifo_full = full_arr[k];
            i_abort     = (k == a);
            reset       = (k == r);
            i_start     = (k == 0) || (hold_start && k <= t);
            i_rec_len   = (k == 0) ? LW'(len) : LW'($urandom);
            @(posedge mclk);
            #1;
            if (k >= r) begin
                e_busy = 0; e_wr = 0; e_done = 0; drops = 0; exp_din = '0;
            end else begin
                e_busy    = (len > 0) && (k < t) && (k < a);
                word_edge = (len > 0) && (k <= t) && (k >= S + W) && ((k - S) % W == 0) && (k < a);
                e_wr      = word_edge && !full_arr[k];
                if (word_edge && full_arr[k]) drops++;
                if (e_wr) begin
                    w = '0;
                    for (int j = 0; j < W; j++) w = {w[W-2:0], mic_arr[k - W + 1 + j]};
                    exp_din = w;
                end
                e_done = (k == t) && (k < a);
            end
            e_cnt = (drops > 255) ? 255 : drops;
            if (o_fifo_wr === 1'b1) nwr++;
            checks += 7;
            if (o_busy !== e_busy) begin
                errors++;
                $display("FAIL %s busy@E%0d: got %b want %b", name, k, o_busy, e_busy);
            end
            if (o_mic_en !== e_busy) begin
                errors++;
                $display("FAIL %s mic_en@E%0d: got %b want %b", name, k, o_mic_en, e_busy);
            end
            if (o_fifo_wr !== e_wr) begin
                errors++;
                $display("FAIL %s fifo_wr@E%0d: got %b want %b", name, k, o_fifo_wr, e_wr);
            end
            if (o_fifo_din !== exp_din) begin
                errors++;
                $display("FAIL %s fifo_din@E%0d: got %h want %h", name, k, o_fifo_din, exp_din);
            end
            if (o_done !== e_done) begin
                errors++;
                $display("FAIL %s done@E%0d: got %b want %b", name, k, o_done, e_done);
            end
            if (o_overrun !== (drops > 0)) begin
                errors++;
                $display("FAIL %s overrun@E%0d: got %b want %b", name, k, o_overrun, drops > 0);
            end
            if (o_overrun_count !== 8'(e_cnt)) begin
                errors++;
                $display("FAIL %s overrun_count@E%0d: got %0d want %0d", name, k, o_overrun_count, e_cnt);
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        reset   = 1'b0;
        checks++;
        if (nwr != exp_total) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, nwr, exp_total);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_start = 1'b1; i_abort = 1'b0; i_rec_len = LW'(5);
        i_mic_data = 1'b1; i_fifo_full = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        checks++;
        if ({o_busy, o_mic_en, o_fifo_wr, o_done, o_overrun, o_overrun_count, o_fifo_din} !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b mic_en=%b wr=%b done=%b ov=%b cnt=%0d din=%h required all 0",
                     o_busy, o_mic_en, o_fifo_wr, o_done, o_overrun, o_overrun_count, o_fifo_din);
        end
        exp_din = '0;
        idle_gap(3);
    endtask

    task automatic test_basic();
        run_rec("basic", 3, 1'b0, 0, 0, -1, 1'b0, -1);
        checks++;
        if (o_fifo_din !== 8'hB2) begin
            errors++;
            $display("FAIL basic_word: got %h want b2", o_fifo_din);
        end
        idle_gap(4);
    endtask

    task automatic test_overrun();
        run_rec("overrun", 4, 1'b1, 1, S + 2 * W, -1, 1'b0, -1);
        checks++;
        if (o_overrun !== 1'b1 || o_overrun_count !== 8'd1) begin
            errors++;
            $display("FAIL overrun_final: ov=%b cnt=%0d want 1/1", o_overrun, o_overrun_count);
        end
        idle_gap(4);
    endtask

    task automatic test_saturation();
        run_rec("saturation", 300, 1'b1, 2, 0, -1, 1'b0, -1);
        checks++;
        if (o_overrun_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation_count: got %0d want 255", o_overrun_count);
        end
        idle_gap(4);
    endtask

    task automatic test_abort_mid_word();
        run_rec("abort_mid", 3, 1'b1, 0, 0, S + 5, 1'b0, -1);
        idle_gap(4);
        run_rec("after_abort", 3, 1'b0, 0, 0, -1, 1'b0, -1);
        idle_gap(4);
    endtask

    task automatic test_edge_handshakes();
        run_rec("zero_len", 0, 1'b1, 0, 0, -1, 1'b0, -1);
        idle_gap(3);
        run_rec("start_held", 2, 1'b1, 3, 0, -1, 1'b1, -1);
        idle_gap(6);
        run_rec("abort_final", 2, 1'b1, 0, 0, S + 2 * W, 1'b0, -1);
        idle_gap(4);
    endtask

    task automatic test_reset_mid_record();
        run_rec("reset_mid", 4, 1'b1, 1, S + 2 * W, -1, 1'b0, S + 2 * W + 3);
        idle_gap(5);
        run_rec("after_reset", 2, 1'b1, 0, 0, -1, 1'b0, -1);
        idle_gap(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_rec("random", $urandom_range(6, 1), 1'b1, 3, 0, -1, 1'b0, -1);
            idle_gap($urandom_range(4, 1));
        end
    endtask

    initial begin
        reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_rec_len = '0;
        i_mic_data = 1'b0; i_fifo_full = 1'b0; exp_din = '0;
        test_reset();
        test_basic();
        test_overrun();
        test_saturation();
        test_abort_mid_word();
        test_edge_handshakes();
        test_reset_mid_record();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
